cordic_accumulator: RTL and testbench

Downstream consumer of the CORDIC datapath: accepts a run of signed fixed-point CORDIC results, sums them in a wide accumulator, and returns the sum as an IEEE-754 single. Sits between `cordic_top`'s fixed-point output and the 32-bit result register seen by software. It replaces the combinational `fixed_to_fp` stage for multi-sample runs.

---
 rtl/cordic_acc_pkg.sv | 19 +
 rtl/acc_to_fp.sv | 47 ++++
 rtl/cordic_accumulator.sv | 156 +++++++++++++++
 tb/tb_cordic_accumulator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_acc_pkg.sv
// Shared types and IEEE-754 constants for the CORDIC result accumulator.
// Saturation is selected with CORDIC_ACC_SATURATE_EN.
package cordic_acc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        NORM,
        PACK,
        DONE
    } state_t;

    localparam int FP_BIAS  = 127;
    localparam int FP_MAN_W = 23;
    localparam int FP_EXP_W = 8;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/acc_to_fp.sv
// Fixed-point accumulator to IEEE-754 single: magnitude/MSB detect and pack.
// Both halves are combinational; the caller registers around them.
module acc_to_fp
    import cordic_acc_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int FRAC_BITS = 19,
    localparam int PW = $clog2(ACC_WIDTH)
) (
    input  logic [ACC_WIDTH-1:0] acc,
    output logic                 sign,
    output logic [ACC_WIDTH-1:0] mag,
    output logic [PW-1:0]        msb,
    input  logic                 pk_sign,
    input  logic [ACC_WIDTH-1:0] pk_mag,
    input  logic [PW-1:0]        pk_msb,
    output logic [31:0]          fp
);

    logic [ACC_WIDTH-1:0] norm;
    logic [FP_EXP_W-1:0]  expo;
    logic                 unused_norm;

    always_comb begin
        sign = acc[ACC_WIDTH-1];
        mag  = sign ? (~acc + 1'b1) : acc;
        msb  = '0;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (mag[i]) msb = PW'(i);
        end
    end

    // Shift the leading one up to the top bit; the mantissa sits just below it.
    always_comb begin
        norm = pk_mag << (PW'(ACC_WIDTH - 1) - pk_msb);
        expo = FP_EXP_W'(FP_BIAS - FRAC_BITS) + FP_EXP_W'(pk_msb);
        if (pk_mag == '0) begin
            fp = FP_ZERO;
        end else begin
            fp = {pk_sign, expo, norm[ACC_WIDTH-2 -: FP_MAN_W]};
        end
    end

    assign unused_norm = ^{norm[ACC_WIDTH-1],
                           norm[ACC_WIDTH-FP_MAN_W-2:0]};

endmodule

// File: rtl/cordic_accumulator.sv
// Sums a run of signed fixed-point CORDIC samples and returns an IEEE-754 single.
// Define CORDIC_ACC_SATURATE_EN for clamping accumulation with a sticky ovf flag.
module cordic_accumulator
    import cordic_acc_pkg::*;
#(
    parameter int WORD_LENGTH = 21,
    parameter int FRAC_BITS   = 19,
    parameter int ACC_WIDTH   = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CNT_WIDTH-1:0]          n,
    input  logic                          in_valid,
    input  logic signed [WORD_LENGTH-1:0] in,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [31:0]                   out,
    input  logic                          out_ack,
    output logic                          ovf,
    output logic                          busy
);

    localparam int PW = $clog2(ACC_WIDTH);

    state_t                      state;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH:0]   sum;
    logic [CNT_WIDTH-1:0]        cnt;
    logic                        accept;

    logic                 nsign;
    logic [ACC_WIDTH-1:0] nmag;
    logic [PW-1:0]        nmsb;
    logic                 psign;
    logic [ACC_WIDTH-1:0] pmag;
    logic [PW-1:0]        pmsb;
    logic [31:0]          fp;

    assign accept = in_valid & in_ready;
    assign sum    = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(in);

`ifdef CORDIC_ACC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
        {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
        {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic sat;

    // Top two sum bits disagree exactly when the signed add overflowed.
    always_comb begin
        sat = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        if (!sat)              acc_next = sum[ACC_WIDTH-1:0];
        else if (sum[ACC_WIDTH]) acc_next = ACC_MIN;
        else                   acc_next = ACC_MAX;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == IDLE && start) begin
            ovf <= 1'b0;
        end else if (accept && sat) begin
            ovf <= 1'b1;
        end
    end
`else
    logic unused_carry;

    assign acc_next     = sum[ACC_WIDTH-1:0];
    assign unused_carry = sum[ACC_WIDTH];
    assign ovf          = 1'b0;
`endif

    acc_to_fp #(
        .ACC_WIDTH (ACC_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_fp (
        .acc     (acc),
        .sign    (nsign),
        .mag     (nmag),
        .msb     (nmsb),
        .pk_sign (psign),
        .pk_mag  (pmag),
        .pk_msb  (pmsb),
        .fp      (fp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out       <= FP_ZERO;
            psign     <= 1'b0;
            pmag      <= '0;
            pmsb      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (n != '0) begin
                            acc      <= '0;
                            cnt      <= n;
                            in_ready <= 1'b1;
                            state    <= ACCUM;
                        end else begin
                            out       <= FP_ZERO;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt - CNT_WIDTH'(1);
                        if (cnt == CNT_WIDTH'(1)) begin
                            in_ready <= 1'b0;
                            state    <= NORM;
                        end
                    end
                end
                NORM: begin
                    psign <= nsign;
                    pmag  <= nmag;
                    pmsb  <= nmsb;
                    state <= PACK;
                end
                PACK: begin
                    out       <= fp;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ack) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_accumulator.sv
// Scoreboard bench for cordic_accumulator: directed runs, expected results queued.
// Honours CORDIC_ACC_SATURATE_EN for the overflow run.
module tb_cordic_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] n;
    logic        in_valid;
    logic [20:0] in;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out;
    logic        out_ack;
    logic        ovf;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    logic [32:0] exp_q[$];
    logic [20:0] smp[$];
    logic        prev_valid = 1'b0;

    cordic_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n         (n),
        .in_valid  (in_valid),
        .in        (in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out       (out),
        .out_ack   (out_ack),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Monitor: one scoreboard pop per rising out_valid.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst && out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_result: got %h want none", out);
            end else begin
                e = exp_q.pop_front();
                check("result", out, e[31:0]);
                check("result_ovf", 32'(ovf), 32'(e[32]));
            end
        end
        prev_valid <= out_valid & ~rst;
    end

    task automatic run(input int gap, input logic [31:0] eo,
                       input logic eov, input bit hold);
        int nn;
        int t;
        int stalls;
        nn = smp.size();
        stalls = 0;
        exp_q.push_back({eov, eo});
        @(negedge clk);
        start = 1'b1;
        n = 16'(nn);
        @(negedge clk);
        start = 1'b0;
        if (nn == 0) begin
            check("zero_rdy", 32'(in_ready), 0);
            check("zero_valid", 32'(out_valid), 1);
        end else begin
            for (int i = 0; i < nn; i++) begin
                in_valid = 1'b1;
                in = smp[i];
                t = 0;
                while (!in_ready && t < 50) begin
                    @(negedge clk);
                    t++;
                    stalls++;
                end
                if (!in_ready) begin
                    check("accept_timeout", 0, 1);
                    in_valid = 1'b0;
                    smp.delete();
                    return;
                end
                @(negedge clk);
                in_valid = 1'b0;
                if (i != nn - 1) repeat (gap) @(negedge clk);
            end
            check("stalls", 32'(stalls), 0);
            check("lat_norm", 32'(out_valid), 0);
            check("rdy_drop", 32'(in_ready), 0);
            @(negedge clk);
            check("lat_pack", 32'(out_valid), 0);
            @(negedge clk);
            check("lat_done", 32'(out_valid), 1);
        end
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                start = i[0];
                n = 16'd5;
                in_valid = 1'b1;
                @(negedge clk);
                check("hold_valid", 32'(out_valid), 1);
                check("hold_out", out, eo);
            end
        end
        start = hold;
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        check("ack_drop", 32'(out_valid), 0);
        check("ack_idle", 32'(busy), 0);
        smp.delete();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        n = '0;
        in_valid = 1'b0;
        in = '0;
        out_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_out", out, 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        // 4 x 1.0 = 4.0
        repeat (4) smp.push_back(21'h080000);
        run(0, 32'h40800000, 1'b0, 1'b0);

        // 1.0 + -0.5 = 0.5, both orders
        smp.push_back(21'h080000);
        smp.push_back(21'h1C0000);
        run(0, 32'h3F000000, 1'b0, 1'b0);
        smp.push_back(21'h1C0000);
        smp.push_back(21'h080000);
        run(0, 32'h3F000000, 1'b0, 1'b0);

        run(0, 32'h00000000, 1'b0, 1'b0);

        // samples offered in IDLE must not start anything
        in_valid = 1'b1;
        in = 21'h0ABCDE;
        repeat (3) @(negedge clk);
        check("idle_ignore", 32'(busy), 0);
        in_valid = 1'b0;

        // 1.0 + 0.5 + 0.25 = 1.75, gapped, then held result
        smp.push_back(21'h080000);
        smp.push_back(21'h040000);
        smp.push_back(21'h020000);
        run(2, 32'h3FE00000, 1'b0, 1'b1);

        // 4096 x 0x0FFFFF: clamps to 0x7FFFFFFF, or wraps to -4096 = -2^-7
        repeat (4096) smp.push_back(21'h0FFFFF);
`ifdef CORDIC_ACC_SATURATE_EN
        run(0, 32'h457FFFFF, 1'b1, 1'b0);
        check("ovf_sticky", 32'(ovf), 1);
`else
        run(0, 32'hBC000000, 1'b0, 1'b0);
        check("ovf_sticky", 32'(ovf), 0);
`endif

        smp.push_back(21'h080000);
        run(0, 32'h3F800000, 1'b0, 1'b0);

        // abort after 2 of 5 samples
        @(negedge clk);
        start = 1'b1;
        n = 16'd5;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in = 21'h080000;
        repeat (2) @(negedge clk);
        check("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("abort_ready", 32'(in_ready), 0);
        check("abort_valid", 32'(out_valid), 0);
        check("abort_out", out, 0);
        check("abort_ovf", 32'(ovf), 0);
        check("abort_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        run(0, 32'h00000000, 1'b0, 1'b0);
        smp.push_back(21'h080000);
        run(0, 32'h3F800000, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        mismatched++;
        $display("FAIL watchdog: got timeout want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
